// File: rtl/spike_time_capture.sv
// Measures the first 1->0 time of each sorted spike lane over one gamma window.
// The packed times and an ordering flag go to a valid/ready consumer.
module spike_time_capture #(
    parameter int N     = 4,
    parameter int TW    = 4,
    parameter int GAMMA = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N-1:0]    spike_in,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [N*TW-1:0] out_times,
    output logic            order_err,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, WINDOW, DONE} state_t;

    localparam logic [TW-1:0] NO_SPIKE   = '1;
    localparam logic [TW-1:0] LAST_COUNT = TW'(GAMMA - 1);

    state_t               state, state_next;
    logic [TW-1:0]        count;
    logic [N-1:0]         prev, captured, captured_next, fall;
    logic [N-1:0][TW-1:0] times, times_next;
    logic                 last_edge, err_next;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        fall          = prev & ~spike_in & ~captured;
        captured_next = captured | fall;
        times_next    = times;
        for (int i = 0; i < N; i++) begin
            if (fall[i]) times_next[i] = count;
        end
        // NO_SPIKE is all ones, so silent trailing lanes never look out of order.
        err_next = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (times_next[i] < times_next[i-1]) err_next = 1'b1;
        end
        last_edge = (count == LAST_COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)     state_next = WINDOW;
            WINDOW:  if (last_edge) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '1;
            count     <= '0;
            captured  <= '0;
            times     <= {N{NO_SPIKE}};
            out_times <= '0;
            order_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        prev     <= spike_in;
                        count    <= '0;
                        captured <= '0;
                        times    <= {N{NO_SPIKE}};
                    end
                end
                WINDOW: begin
                    prev     <= spike_in;
                    captured <= captured_next;
                    times    <= times_next;
                    count    <= count + TW'(1);
                    // Result is latched with this edge's captures already folded in.
                    if (last_edge) begin
                        out_times <= times_next;
                        order_err <= err_next;
                    end
                end
                DONE: begin
                    if (out_ready) order_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_time_capture.sv
// Randomized and directed bench for spike_time_capture against a
// first-falling-edge reference model computed from the whole sample sequence.
module tb_spike_time_capture;

    localparam int N        = 4;
    localparam int TW       = 4;
    localparam int GAMMA    = 8;
    localparam int NO_SPIKE = 15;

    typedef logic [N-1:0] samp_t [0:GAMMA];

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [N-1:0]    spike_in;
    logic            out_ready;
    logic            out_valid;
    logic [N*TW-1:0] out_times;
    logic            order_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    spike_time_capture #(.N(N), .TW(TW), .GAMMA(GAMMA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .spike_in  (spike_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_times (out_times),
        .order_err (order_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: per lane, the first k in 1..GAMMA with s[k-1]=1 and s[k]=0 gives time k-1.
    function automatic void model(input samp_t s, output logic [N*TW-1:0] t, output logic err);
        int  tm [N];
        bit  found;
        for (int i = 0; i < N; i++) begin
            tm[i] = NO_SPIKE;
            found = 1'b0;
            for (int k = 1; k <= GAMMA; k++) begin
                if (!found && s[k-1][i] && !s[k][i]) begin
                    tm[i] = k - 1;
                    found = 1'b1;
                end
            end
        end
        err = 1'b0;
        for (int i = 1; i < N; i++) if (tm[i] < tm[i-1]) err = 1'b1;
        for (int i = 0; i < N; i++) t[i*TW +: TW] = TW'(tm[i]);
    endfunction

    // Entered just after an edge with the DUT idle; leaves just after the handshake edge.
    task automatic run_window(input string tag, input samp_t s, input int hold, input bit poke);
        logic [N*TW-1:0] exp_t;
        logic            exp_err;
        model(s, exp_t, exp_err);
        start     = 1'b1;
        spike_in  = s[0];
        out_ready = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        for (int k = 1; k <= GAMMA; k++) begin
            spike_in  = s[k];
            start     = (k == 3);
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (k == GAMMA - 1) begin
                check({tag, "_valid_early"}, 64'(out_valid), 64'd0);
                check({tag, "_busy_window"}, 64'(busy), 64'd1);
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_times"}, 64'(out_times), 64'(exp_t));
        check({tag, "_err"},   64'(order_err), 64'(exp_err));
        for (int c = 0; c < hold; c++) begin
            start    = poke;
            spike_in = N'($urandom);
            step();
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_times"}, 64'(out_times), 64'(exp_t));
            check({tag, "_hold_err"},   64'(order_err), 64'(exp_err));
        end
        start     = poke;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_hs_busy"},  64'(busy), 64'd0);
        check({tag, "_hs_err"},   64'(order_err), 64'd0);
        check({tag, "_hs_times"}, 64'(out_times), 64'(exp_t));
    endtask

    initial begin
        samp_t s;
        logic [N-1:0] hi;
        int fall_k [N];

        rst_n     = 1'b0;
        start     = 1'b0;
        spike_in  = '1;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_times", 64'(out_times), 64'd0);
        check("rst_err",   64'(order_err), 64'd0);
        #2 rst_n = 1'b1;
        step();

        for (int k = 0; k <= GAMMA; k++) s[k] = {1'b1, k < 6, k < 3, k < 3};
        run_window("falls", s, 0, 1'b0);

        for (int k = 0; k <= GAMMA; k++) s[k] = {1'b1, 1'b1, k < 2, k < 5};
        run_window("out_of_order", s, 1, 1'b0);

        for (int k = 0; k <= GAMMA; k++) s[k] = {1'b1, 1'b1, k < 1, k < 8};
        run_window("boundary", s, 2, 1'b0);

        for (int k = 0; k <= GAMMA; k++) s[k] = {1'b1, (k == 2 || k == 3 || k == 5), 1'b1, 1'b1};
        run_window("first_edge", s, 0, 1'b0);

        for (int k = 0; k <= GAMMA; k++) s[k] = N'($urandom);
        run_window("backpressure", s, 5, 1'b1);

        // Mid-window reset: start, run to edge 4, then pull rst_n between edges.
        start    = 1'b1;
        spike_in = '1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            spike_in = (k >= 2) ? 4'b0000 : 4'b1111;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_times", 64'(out_times), 64'd0);
        check("mid_rst_err",   64'(order_err), 64'd0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < GAMMA + 2; c++) begin
            spike_in = N'($urandom);
            step();
            check("mid_rst_no_result", 64'({out_valid, busy}), 64'd0);
        end
        for (int k = 0; k <= GAMMA; k++) s[k] = {k < 7, k < 4, k < 4, 1'b1};
        run_window("after_reset", s, 1, 1'b0);

        // Random sorted-ish falls plus fully random glitchy lines.
        for (int r = 0; r < 24; r++) begin
            if (r % 2 == 0) begin
                for (int i = 0; i < N; i++) fall_k[i] = $urandom_range(1, GAMMA + 2);
                for (int k = 0; k <= GAMMA; k++) begin
                    for (int i = 0; i < N; i++) hi[i] = (k < fall_k[i]);
                    s[k] = hi;
                end
            end else begin
                for (int k = 0; k <= GAMMA; k++) s[k] = N'($urandom);
            end
            run_window($sformatf("rand%0d", r), s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
